systolic_tile_scheduler: RTL
============================

Name: systolic_tile_scheduler

Overview:
- Sequences one full K-tiled matrix multiply C = A(M×K) · W(K×N_SIZE) on the systolic top.
- For each K-tile it loads N_SIZE weight rows, streams M activation rows, then inserts N_SIZE-1 zero drain rows and waits for the array's done.
- It drives first_iteration and last_tile so partial sums accumulate and the final tile lands in the output buffer.
- It sits between the global control/fetch logic and the systolic top.

Parameters:
- N_SIZE, 32, array dimension; also the weight rows per K-tile and drain length + 1.
- MAX_ROWS, 512, maximum legal M (output/partial-sum buffer capacity).
- A_ADDR_WIDTH, 16, activation buffer address width.
- W_ADDR_WIDTH, 12, weight buffer address width.
- KT_WIDTH, 8, width of the K-tile count.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; latches cfg_rows and cfg_ktiles and begins a job.
- cfg_rows  input  $clog2(MAX_ROWS)+1  M, rows of A per tile.
- cfg_ktiles  input  KT_WIDTH  number of K-tiles.
- sa_ready  input  1  systolic top ready.
- sa_done  input  1  systolic top done pulse for the current tile.
- a_rd_en  output  1  activation buffer read strobe.
- a_rd_addr  output  A_ADDR_WIDTH  activation address, equal to kt*cfg_rows + row.
- wt_rd_en  output  1  weight buffer read strobe.
- wt_rd_addr  output  W_ADDR_WIDTH  weight address, equal to kt*N_SIZE + r.
- sa_load_weight  output  1  to systolic top load_weight.
- sa_valid_in  output  1  to systolic top valid_in.
- sa_zero_fill  output  1  fetch mux forces in_A to zero.
- sa_first_iteration  output  1  high for the whole of K-tile 0.
- sa_last_tile  output  1  high for the whole of the final K-tile.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse at job end.
- cfg_err  output  1  one-cycle pulse when a job is rejected.

Behaviour:
- Reset: every output is 0, FSM in IDLE, all counters 0.
  - Reset mid-job aborts immediately.
  - No done pulse is produced for the aborted job.
- Buffer read latency is 1 cycle.
  - sa_load_weight equals wt_rd_en delayed by one register.
  - sa_valid_in equals (a_rd_en | drain) delayed by one register.
  - sa_zero_fill equals drain delayed by one register.
- FSM states: IDLE, LOAD_W, WAIT_RDY, STREAM, DRAIN, WAIT_DONE, FINISH.
- IDLE:
  - start with cfg_rows==0, cfg_ktiles==0 or cfg_rows>MAX_ROWS: pulse cfg_err next cycle, stay IDLE.
  - Otherwise latch the config, set kt=0, go to LOAD_W; busy rises the next cycle.
- LOAD_W: wt_rd_en high for exactly N_SIZE cycles, r=0..N_SIZE-1, then go to WAIT_RDY.
- WAIT_RDY: hold all strobes low until sa_ready==1 (checked one cycle after the last weight strobe), then go to STREAM.
- STREAM: a_rd_en high for exactly cfg_rows consecutive cycles, then go to DRAIN.
- DRAIN: N_SIZE-1 cycles with a_rd_en=0 and drain=1, then go to WAIT_DONE.
- WAIT_DONE: on sa_done:
  - If kt==cfg_ktiles-1, go to FINISH.
  - Otherwise kt++ and go to LOAD_W.
  - sa_done is ignored in every other state.
- FINISH: pulse done for one cycle, clear busy in the same cycle, return to IDLE.
- sa_first_iteration = busy & (kt==0); sa_last_tile = busy & (kt==cfg_ktiles-1).
  - Both are registered with kt and stay stable across every cycle of the tile, including the delayed strobes.
  - With a single K-tile both are high together.
- start while busy is ignored; the latched config is unchanged.
- Address arithmetic is unsigned; a result that overflows its address width wraps modulo 2^width with no error.
- The strobes wt_rd_en and a_rd_en are never asserted in the same cycle.
- The delayed strobes sa_load_weight and sa_valid_in are never high in the same cycle.
- At most one of these states owns the strobe bus in any cycle: LOAD_W, STREAM, DRAIN.

Test Plan:
- N_SIZE=4, rows=3, ktiles=1, sa_ready=1, sa_done returned 5 cycles after drain:
  - wt_rd_addr runs 0,1,2,3, then a_rd_addr runs 0,1,2.
  - 3 drain cycles with sa_zero_fill=1.
  - first_iteration=last_tile=1 throughout; done pulses once and busy falls in the same cycle.
- N_SIZE=4, rows=2, ktiles=3:
  - wt_rd_addr runs 0-3, 4-7, 8-11; a_rd_addr runs {0,1}, {2,3}, {4,5}.
  - first_iteration only in tile 0; last_tile only in tile 2; sa_valid_in high for 5 cycles per tile.
- Hold sa_ready=0 for 10 cycles after LOAD_W: no a_rd_en until 1 cycle after sa_ready rises; the stream then proceeds normally.
- Configuration errors:
  - start with rows=0 → cfg_err pulse, busy stays 0, no strobes.
  - Same for ktiles=0 and for rows=MAX_ROWS+1.
- Spurious control inputs:
  - start pulse mid-STREAM → ignored, addresses continue unchanged.
  - sa_done during LOAD_W → ignored, tile count unchanged.
- Assert rst_n=0 during DRAIN of tile 1:
  - All outputs 0 asynchronously; no done pulse.
  - A fresh start runs the full job from kt=0.

Source files
------------

// File: rtl/systolic_tile_scheduler.sv
// systolic_tile_scheduler
// Sequences one K-tiled matrix multiply C = A(M x K) * W(K x N_SIZE) on the
// systolic top. Each K-tile loads N_SIZE weight rows, streams M activation
// rows, pushes N_SIZE-1 zero drain rows and waits for the array's done pulse.
// first_iteration / last_tile steer partial-sum accumulation and the final
// write-back into the output buffer.
module systolic_tile_scheduler #(
    parameter int N_SIZE       = 32,
    parameter int MAX_ROWS     = 512,
    parameter int A_ADDR_WIDTH = 16,
    parameter int W_ADDR_WIDTH = 12,
    parameter int KT_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [$clog2(MAX_ROWS):0] cfg_rows,
    input  logic [KT_WIDTH-1:0]       cfg_ktiles,
    input  logic                      sa_ready,
    input  logic                      sa_done,
    output logic                      a_rd_en,
    output logic [A_ADDR_WIDTH-1:0]   a_rd_addr,
    output logic                      wt_rd_en,
    output logic [W_ADDR_WIDTH-1:0]   wt_rd_addr,
    output logic                      sa_load_weight,
    output logic                      sa_valid_in,
    output logic                      sa_zero_fill,
    output logic                      sa_first_iteration,
    output logic                      sa_last_tile,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    // One counter walks weight rows, activation rows and drain rows in turn,
    // so it must be wide enough for the larger of MAX_ROWS and N_SIZE.
    localparam int ROW_W  = $clog2(MAX_ROWS) + 1;
    localparam int NCNT_W = $clog2(N_SIZE) + 1;
    localparam int CNT_W  = (ROW_W > NCNT_W) ? ROW_W : NCNT_W;

    localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(N_SIZE - 1);
    localparam logic [CNT_W-1:0] D_LAST   = CNT_W'(N_SIZE - 2);
    localparam logic [ROW_W-1:0] ROWS_MAX = ROW_W'(MAX_ROWS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        WAIT_RDY,
        STREAM,
        DRAIN,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]        cnt;
    logic [KT_WIDTH-1:0]     kt;
    logic [ROW_W-1:0]        rows_q;
    logic [KT_WIDTH-1:0]     ktiles_q;
    logic [A_ADDR_WIDTH-1:0] a_base;
    logic [W_ADDR_WIDTH-1:0] w_base;

    logic load_weight_q;
    logic valid_q;
    logic zero_q;
    logic cfg_err_q;

    logic wt_en;
    logic a_en;
    logic drain;
    logic cnt_inc;
    logic cnt_clr;
    logic latch_cfg;
    logic reject;
    logic tile_next;
    logic job_clear;

    logic             cfg_bad;
    logic             last_kt;
    logic [CNT_W-1:0] row_last;

    assign cfg_bad  = (cfg_rows == '0) || (cfg_ktiles == '0) || (cfg_rows > ROWS_MAX);
    assign last_kt  = (kt == (ktiles_q - KT_WIDTH'(1)));
    assign row_last = CNT_W'(rows_q) - CNT_W'(1);

    // State register; reset aborts any job in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the strobes and counter controls owned by each state.
    always_comb begin
        state_next = state;
        wt_en      = 1'b0;
        a_en       = 1'b0;
        drain      = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        latch_cfg  = 1'b0;
        reject     = 1'b0;
        tile_next  = 1'b0;
        job_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        reject = 1'b1;
                    end else begin
                        latch_cfg  = 1'b1;
                        state_next = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                wt_en = 1'b1;
                if (cnt == W_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = WAIT_RDY;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_RDY: begin
                if (sa_ready) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                a_en = 1'b1;
                if (cnt == row_last) begin
                    cnt_clr    = 1'b1;
                    state_next = (N_SIZE > 1) ? DRAIN : WAIT_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DRAIN: begin
                drain = 1'b1;
                if (cnt == D_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = WAIT_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (sa_done) begin
                    if (last_kt) begin
                        state_next = FINISH;
                    end else begin
                        tile_next  = 1'b1;
                        state_next = LOAD_W;
                    end
                end
            end
            FINISH: begin
                job_clear  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Row counter, tile index, latched config and per-tile address bases.
    // Bases advance by rows / N_SIZE per tile, so kt*rows needs no multiplier
    // and both wrap modulo their address width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            kt       <= '0;
            rows_q   <= '0;
            ktiles_q <= '0;
            a_base   <= '0;
            w_base   <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (latch_cfg) begin
                rows_q   <= cfg_rows;
                ktiles_q <= cfg_ktiles;
                kt       <= '0;
                a_base   <= '0;
                w_base   <= '0;
                cnt      <= '0;
            end
            if (tile_next) begin
                kt     <= kt + KT_WIDTH'(1);
                a_base <= a_base + A_ADDR_WIDTH'(rows_q);
                w_base <= w_base + W_ADDR_WIDTH'(N_SIZE);
            end
            if (job_clear) begin
                kt     <= '0;
                a_base <= '0;
                w_base <= '0;
            end
        end
    end

    // Strobes delayed by the one-cycle buffer read latency, plus the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_weight_q <= 1'b0;
            valid_q       <= 1'b0;
            zero_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            load_weight_q <= wt_en;
            valid_q       <= a_en | drain;
            zero_q        <= drain;
            cfg_err_q     <= reject;
        end
    end

    assign wt_rd_en   = wt_en;
    assign a_rd_en    = a_en;
    assign wt_rd_addr = wt_en ? (w_base + W_ADDR_WIDTH'(cnt)) : '0;
    assign a_rd_addr  = a_en ? (a_base + A_ADDR_WIDTH'(cnt)) : '0;

    assign sa_load_weight = load_weight_q;
    assign sa_valid_in    = valid_q;
    assign sa_zero_fill   = zero_q;
    assign cfg_err        = cfg_err_q;

    // busy drops in the FINISH cycle so done and the busy fall coincide.
    assign busy               = (state != IDLE) && (state != FINISH);
    assign done               = (state == FINISH);
    assign sa_first_iteration = busy && (kt == '0);
    assign sa_last_tile       = busy && last_kt;

    // Only one of the two read strobes and one of the delayed strobes may be live.
    assert property (@(posedge clk) disable iff (!rst_n) !(wt_rd_en && a_rd_en));
    assert property (@(posedge clk) disable iff (!rst_n) !(sa_load_weight && sa_valid_in));
    assert property (@(posedge clk) disable iff (!rst_n) !(done && busy));

endmodule
